// File: rtl/cdc_channel_arbiter_pkg.sv
// Shared definitions for the toggle-handshake channel arbiter: FSM state
// encodings and a constant-evaluable clog2 used to size indices and counters.
package cdc_arb_defs;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LAUNCH   = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_DRAIN    = 2'd3
   } arb_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/cdc_channel_arbiter_picker.sv
// Round-robin priority picker: returns the first set request found scanning
// from ptr_i upward with wrap. ptr_i must be below N.
module rr_priority_picker
   import cdc_arb_defs::*;
#(
   parameter int N = 4,
   localparam int IW = (N > 1) ? clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   // Scan from the farthest offset down so the nearest set request wins.
   always_comb begin : pick_scan
      int c;
      found_o = 1'b0;
      idx_o   = '0;
      c       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         c       = (int'(ptr_i) + k >= N) ? int'(ptr_i) + k - N : int'(ptr_i) + k;
         found_o = req_i[c] ? 1'b1 : found_o;
         idx_o   = req_i[c] ? IW'(c) : idx_o;
      end
   end

endmodule

// File: rtl/cdc_channel_arbiter.sv
// Shares one toggle-handshake clock-crossing channel among NREQ requesters with
// round-robin grants, a per-transfer timeout, and drain recovery after timeout.
module cdc_channel_arbiter
   import cdc_arb_defs::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = 16,
   parameter int TIMEOUT = 255,
   localparam int IW     = (NREQ > 1) ? clog2(NREQ) : 1,
   localparam int CW     = clog2(TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0] req_done,
   output logic [NREQ-1:0] req_err,
   output logic [W-1:0]    xfer_data,
   output logic            xfer_req_tgl,
   input  logic            ack_tgl_sync,
   output logic            busy,
   output logic [IW-1:0]   grant_idx
);

   arb_state_e      state_q;
   logic [W-1:0]    xfer_data_q;
   logic            tgl_q;
   logic [NREQ-1:0] done_q;
   logic [NREQ-1:0] err_q;
   logic            busy_q;
   logic [IW-1:0]   grant_q;
   logic [IW-1:0]   rr_q;
   logic [CW-1:0]   cnt_q;

   logic            pick_found_s;
   logic [IW-1:0]   pick_idx_s;
   logic [W-1:0]    sel_data_s;
   logic [IW-1:0]   rr_d;

   rr_priority_picker #(.N(NREQ)) u_picker (
      .req_i   (req_valid),
      .ptr_i   (rr_q),
      .found_o (pick_found_s),
      .idx_o   (pick_idx_s)
   );

   // Word of the requester the picker currently favours.
   always_comb begin
      sel_data_s = req_data[int'(pick_idx_s)*W +: W];
   end

   // Pointer moves just past the requester being retired.
   always_comb begin
      if (NREQ == 1) begin
         rr_d = '0;
      end else if (int'(grant_q) == NREQ - 1) begin
         rr_d = '0;
      end else begin
         rr_d = grant_q + IW'(1);
      end
   end

   // Channel FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         xfer_data_q <= '0;
         tgl_q       <= 1'b0;
         done_q      <= '0;
         err_q       <= '0;
         busy_q      <= 1'b0;
         grant_q     <= '0;
         rr_q        <= '0;
         cnt_q       <= '0;
      end else begin
         done_q <= '0;
         err_q  <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_found_s) begin
                  grant_q     <= pick_idx_s;
                  xfer_data_q <= sel_data_s;
                  busy_q      <= 1'b1;
                  state_q     <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               tgl_q   <= ~tgl_q;
               cnt_q   <= '0;
               state_q <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               if (ack_tgl_sync == tgl_q) begin
                  done_q[grant_q] <= 1'b1;
                  rr_q            <= rr_d;
                  busy_q          <= 1'b0;
                  state_q         <= ST_IDLE;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  err_q[grant_q] <= 1'b1;
                  rr_q           <= rr_d;
                  state_q        <= ST_DRAIN;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            // The late acknowledge must be absorbed before a new launch.
            ST_DRAIN: begin
               if (ack_tgl_sync == tgl_q) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_done     = done_q;
   assign req_err      = err_q;
   assign xfer_data    = xfer_data_q;
   assign xfer_req_tgl = tgl_q;
   assign busy         = busy_q;
   assign grant_idx    = grant_q;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Scoreboard bench: stimulus pushes the round-robin order predicted by a
// queue-level model; a negedge monitor checks launches and done/err pulses.
module tb_cdc_channel_arbiter;

   localparam int NREQ     = 4;
   localparam int W        = 16;
   localparam int TO       = 8;
   localparam int LAT_DONE = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_done;
   logic [3:0]  req_err;
   logic [15:0] xfer_data;
   logic        xfer_req_tgl;
   logic        ack_tgl_sync;
   logic        busy;
   logic [1:0]  grant_idx;

   cdc_channel_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_done(req_done), .req_err(req_err), .xfer_data(xfer_data),
      .xfer_req_tgl(xfer_req_tgl), .ack_tgl_sync(ack_tgl_sync), .busy(busy),
      .grant_idx(grant_idx)
   );

   always #5 clk = ~clk;

   // Far domain: echoes the request toggle back after four cycles.
   logic       echo_en;
   logic [3:0] dly;
   always @(posedge clk) begin
      if (reset) dly <= 4'd0;
      else if (echo_en) dly <= {dly[2:0], xfer_req_tgl};
   end
   assign ack_tgl_sync = dly[3];

   typedef struct {
      int          idx;
      logic [15:0] data;
      bit          err;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   bit          cur_v = 1'b0;
   int          cur_cyc;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          model_rr = 0;
   logic        prev_tgl = 1'b0;
   logic [15:0] prev_data = 16'd0;
   logic [15:0] captured[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: launches pop the expected queue, pulses retire the in-flight entry.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         cur_v = 1'b0;
      end else begin
         if (xfer_req_tgl !== prev_tgl) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_launch: got idx %0d data %0h expected none", grant_idx, xfer_data);
            end else begin
               cur     = exp_q.pop_front();
               cur_v   = 1'b1;
               cur_cyc = cyc;
               captured.push_back(xfer_data);
               chk("grant_idx", 32'(grant_idx), 32'(cur.idx));
               chk("xfer_data", 32'(xfer_data), 32'(cur.data));
               chk("data_setup", 32'(prev_data), 32'(cur.data));
               chk("busy_wait", 32'(busy), 32'd1);
            end
         end
         if ((req_done | req_err) != 4'd0) begin
            if (!cur_v) begin
               tests++; fails++;
               $display("FAIL unexpected_pulse: got done %0h err %0h expected none", req_done, req_err);
            end else begin
               chk("done_vec", 32'(req_done), cur.err ? 32'd0 : (32'd1 << cur.idx));
               chk("err_vec", 32'(req_err), cur.err ? (32'd1 << cur.idx) : 32'd0);
               chk("latency", 32'(cyc - cur_cyc), cur.err ? 32'(TO) : 32'(LAT_DONE));
               chk("busy_after", 32'(busy), cur.err ? 32'd1 : 32'd0);
               cur_v = 1'b0;
            end
         end
      end
      prev_tgl  = xfer_req_tgl;
      prev_data = xfer_data;
   end

   // Reference: serve the set in round-robin order from the model pointer.
   task automatic plan(input logic [3:0] mask, input logic [63:0] data, input bit is_err);
      int         ptr;
      logic [3:0] m;
      exp_t       e;
      ptr = model_rr;
      m   = mask;
      while (m != 4'd0) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (m[i]) begin
               e.idx  = i;
               e.data = data[i*16 +: 16];
               e.err  = is_err;
               exp_q.push_back(e);
               m[i] = 1'b0;
               ptr  = (i + 1) % NREQ;
               break;
            end
         end
      end
      model_rr = ptr;
   endtask

   task automatic run_batch(input logic [3:0] mask, input logic [63:0] data,
                            input bit is_err, input bit drop_on_grant);
      logic [3:0] pend;
      plan(mask, data, is_err);
      req_data  = data;
      req_valid = mask;
      pend      = mask;
      for (int t = 0; t < 400 && pend != 4'd0; t++) begin
         @(negedge clk);
         pend      = pend & ~(req_done | req_err);
         req_valid = req_valid & ~(req_done | req_err);
         if (drop_on_grant && busy) req_valid = 4'd0;
      end
      if (pend != 4'd0) begin
         tests++; fails++;
         $display("FAIL batch_timeout: got pending %0h expected 0", pend);
         exp_q.delete();
      end
      req_valid = 4'd0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_xfer_data"}, 32'(xfer_data), 32'd0);
      chk({tag, "_tgl"}, 32'(xfer_req_tgl), 32'd0);
      chk({tag, "_done"}, 32'(req_done), 32'd0);
      chk({tag, "_err"}, 32'(req_err), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_grant"}, 32'(grant_idx), 32'd0);
   endtask

   initial begin
      logic t0;
      bit   seen;
      reset     = 1'b1;
      req_valid = 4'd0;
      req_data  = 64'd0;
      echo_en   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      reset = 1'b0;

      // Single request on index 1.
      run_batch(4'b0010, 64'h0000_0000_A5A5_0000, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Serve index 3 so the next round starts at 0, then two full rounds.
      run_batch(4'b1000, 64'h7777_0000_0000_0000, 1'b0, 1'b0);
      captured.delete();
      run_batch(4'b1111, 64'h4444_3333_2222_1111, 1'b0, 1'b0);
      run_batch(4'b1111, 64'h4444_3333_2222_1111, 1'b0, 1'b0);
      chk("rr_count", 32'(captured.size()), 32'd8);
      if (captured.size() == 8) begin
         for (int i = 0; i < 8; i++)
            chk("rr_capture", 32'(captured[i]), 32'h1111 * 32'((i % 4) + 1));
      end

      // Pointer fairness: after index 2, {0,3} go 3 then 0.
      run_batch(4'b0100, 64'h0000_5555_0000_0000, 1'b0, 1'b0);
      run_batch(4'b1001, 64'hD003_0000_0000_D000, 1'b0, 1'b0);

      // Timeout with drain, then a fresh request must take the full round trip.
      echo_en = 1'b0;
      run_batch(4'b0001, 64'h0000_0000_0000_BEEF, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("drain_busy", 32'(busy), 32'd1);
      end
      echo_en = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = !busy;
      end
      chk("drain_exit", 32'(seen), 32'd1);
      run_batch(4'b0010, 64'h0000_0000_C0DE_0000, 1'b0, 1'b0);

      // Reset while waiting for the acknowledge.
      plan(4'b0100, 64'h0000_1234_0000_0000, 1'b0);
      req_data  = 64'h0000_1234_0000_0000;
      req_valid = 4'b0100;
      t0   = xfer_req_tgl;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = (xfer_req_tgl != t0);
      end
      chk("reset_launch", 32'(seen), 32'd1);
      reset     = 1'b1;
      req_valid = 4'd0;
      @(posedge clk);
      #1;
      chk_reset_outputs("midreset");
      @(posedge clk);
      #1;
      reset    = 1'b0;
      model_rr = 0;
      exp_q.delete();
      run_batch(4'b0110, 64'h0000_6262_6161_0000, 1'b0, 1'b0);

      // Requester drops its valid while in LAUNCH.
      run_batch(4'b0100, 64'h0000_DDDD_0000_0000, 1'b0, 1'b1);

      // Randomized batches.
      for (int n = 0; n < 20; n++) begin
         logic [3:0]  m;
         logic [63:0] d;
         m = 4'($urandom_range(1, 15));
         d = {$urandom(), $urandom()};
         run_batch(m, d, 1'b0, 1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (10) @(negedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("final_busy", 32'(busy), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish by 200000");
      $fatal(1, "watchdog");
   end

endmodule
